// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// mem_arbiter_pkg : shared core constants, arbiter state/owner encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    localparam int XLEN_DEFAULT       = 32;
    localparam int STREAK_MAX_DEFAULT = 4;

    // RV32I major opcodes
    localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] C_OPC_OP     = 7'b0110011;
    localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;

    localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

endpackage : mem_arbiter_pkg

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : fetch/data arbiter onto a single memory port, starvation-capped
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int STREAK_MAX = STREAK_MAX_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int C_SW = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);

    arb_state_e      state_q, state_d;
    owner_e          owner_q, owner_d;
    logic [C_SW-1:0] streak_q, streak_d;
    logic            mreq_q, mreq_d;
    logic            mwe_q, mwe_d;
    logic [XLEN-1:0] maddr_q, maddr_d;
    logic [XLEN-1:0] mwdata_q, mwdata_d;

    logic w_streak_full;
    logic w_pick_d;
    logic w_grant;
    logic w_rsp_hit;

    // Fetch wins only when it is waiting and data has used up its streak.
    assign w_streak_full = (streak_q == C_SW'(STREAK_MAX));
    assign w_pick_d      = d_req & ~(if_req & w_streak_full);
    assign w_grant       = ~rst & (state_q == ST_IDLE) & (if_req | d_req);
    assign w_rsp_hit     = ~rst & (state_q == ST_RSP) & mem_rvalid;

    assign d_gnt     = w_grant & w_pick_d;
    assign if_gnt    = w_grant & ~w_pick_d;
    assign if_rvalid = w_rsp_hit & (owner_q == OWN_IF);
    assign d_rvalid  = w_rsp_hit & (owner_q == OWN_D);
    assign rdata     = w_rsp_hit ? mem_rdata : '0;

    assign mem_req   = mreq_q;
    assign mem_we    = mwe_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = mwdata_q;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        streak_d = streak_q;
        mreq_d   = mreq_q;
        mwe_d    = mwe_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        case (state_q)
            ST_IDLE: begin
                if (if_req | d_req) begin
                    state_d = ST_REQ;
                    mreq_d  = 1'b1;
                    if (w_pick_d) begin
                        owner_d  = OWN_D;
                        mwe_d    = d_we;
                        maddr_d  = d_addr;
                        mwdata_d = d_wdata;
                        // A waiting fetch with a full streak never reaches here, so no overflow.
                        if (if_req) begin
                            streak_d = streak_q + 1'b1;
                        end
                    end else begin
                        owner_d  = OWN_IF;
                        mwe_d    = 1'b0;
                        maddr_d  = if_addr;
                        mwdata_d = '0;
                        streak_d = '0;
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    state_d  = ST_RSP;
                    mreq_d   = 1'b0;
                    mwe_d    = 1'b0;
                    maddr_d  = '0;
                    mwdata_d = '0;
                end
            end
            ST_RSP: begin
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_IF;
            streak_q <= '0;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
            mreq_q   <= mreq_d;
            mwe_q    <= mwe_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
        end
    end

endmodule : mem_arbiter

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed scenarios with a transaction-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int XLEN = 32;
    localparam int SMAX = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req, if_gnt, if_rvalid;
    logic [XLEN-1:0] if_addr;
    logic            d_req, d_we, d_gnt, d_rvalid;
    logic [XLEN-1:0] d_addr, d_wdata, rdata;
    logic            mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.XLEN(XLEN), .STREAK_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } dtx_t;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    dtx_t            dq[$];
    logic [XLEN-1:0] iq[$];
    bit              saw_dgnt = 1'b0;
    bit              saw_ignt = 1'b0;

    // memory responder knobs
    int              gnt_delay = 0;
    int              rsp_delay = 1;
    logic [XLEN-1:0] rsp_data  = 32'h1234_5678;
    int              rs_phase  = 0;
    int              rs_cnt    = 0;

    // reference model: one transaction in flight, accepted or not
    bit              m_busy   = 1'b0;
    bit              m_acc    = 1'b0;
    bit              m_own_d  = 1'b0;
    logic            m_we     = 1'b0;
    logic [XLEN-1:0] m_addr   = '0;
    logic [XLEN-1:0] m_wdata  = '0;
    int              m_streak = 0;

    // scenario observations
    string           glog = "";
    int              ignt_cyc = 0, irv_cyc = 0, drv_cyc = 0;
    logic [XLEN-1:0] irv_data = '0;
    logic [XLEN-1:0] maddr_seen = '0;
    int              rv_count = 0;
    int              mreq_cycles = 0;
    bit              wdata_seen = 1'b0;

    // Requesters hold until granted; responder reacts to mem_req with set delays.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (saw_dgnt && dq.size() > 0) void'(dq.pop_front());
        if (saw_ignt && iq.size() > 0) void'(iq.pop_front());
        d_req   = (dq.size() > 0);
        d_we    = d_req ? dq[0].we    : 1'b0;
        d_addr  = d_req ? dq[0].addr  : '0;
        d_wdata = d_req ? dq[0].wdata : '0;
        if_req  = (iq.size() > 0);
        if_addr = if_req ? iq[0] : '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hA5A5_0000 ^ 32'(cyc);
        if (rs_phase == 0) begin
            if (mem_req) begin
                if (rs_cnt >= gnt_delay) begin
                    mem_gnt  = 1'b1;
                    rs_phase = 1;
                    rs_cnt   = 0;
                end else begin
                    rs_cnt++;
                end
            end
        end else begin
            rs_cnt++;
            if (rs_cnt >= rsp_delay) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rsp_data;
                rs_phase   = 0;
                rs_cnt     = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic            e_ig, e_dg, e_irv, e_drv, e_mreq, e_mwe;
        logic [XLEN-1:0] e_rd, e_ma, e_mwd;
        bit              pick_d;
        e_ig = 1'b0; e_dg = 1'b0; e_irv = 1'b0; e_drv = 1'b0; e_rd = '0;
        pick_d = 1'b0;
        e_mreq = m_busy && !m_acc;
        e_mwe  = e_mreq && m_we;
        e_ma   = e_mreq ? m_addr  : '0;
        e_mwd  = e_mreq ? m_wdata : '0;
        if (!rst && !m_busy && (if_req || d_req)) begin
            pick_d = d_req && !(if_req && m_streak == SMAX);
            e_dg   = pick_d;
            e_ig   = !pick_d;
        end
        if (!rst && m_busy && m_acc && mem_rvalid) begin
            e_irv = !m_own_d;
            e_drv = m_own_d;
            e_rd  = mem_rdata;
        end

        vecs++;
        if ({if_gnt, d_gnt} !== {e_ig, e_dg}) begin
            errs++;
            $display("FAIL gnt cyc %0d: if_gnt/d_gnt got %b%b want %b%b", cyc, if_gnt, d_gnt, e_ig, e_dg);
        end
        vecs++;
        if ({if_rvalid, d_rvalid} !== {e_irv, e_drv}) begin
            errs++;
            $display("FAIL rvalid cyc %0d: if/d got %b%b want %b%b", cyc, if_rvalid, d_rvalid, e_irv, e_drv);
        end
        if (!(e_drv && m_we)) begin
            vecs++;
            if (rdata !== e_rd) begin
                errs++;
                $display("FAIL rdata cyc %0d: got %h want %h", cyc, rdata, e_rd);
            end
        end
        vecs++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {e_mreq, e_mwe, e_ma, e_mwd}) begin
            errs++;
            $display("FAIL membus cyc %0d: got req=%b we=%b a=%h wd=%h want req=%b we=%b a=%h wd=%h",
                     cyc, mem_req, mem_we, mem_addr, mem_wdata, e_mreq, e_mwe, e_ma, e_mwd);
        end

        if (if_gnt) begin glog = {glog, "I"}; ignt_cyc = cyc; end
        if (d_gnt)  glog = {glog, "D"};
        if (if_rvalid) begin irv_cyc = cyc; irv_data = rdata; end
        if (d_rvalid) drv_cyc = cyc;
        if (if_rvalid || d_rvalid) rv_count++;
        if (mem_req) begin mreq_cycles++; maddr_seen = mem_addr; end
        if (mem_req && mem_we && mem_wdata == 32'hDEAD_BEEF) wdata_seen = 1'b1;
        saw_dgnt = (d_gnt === 1'b1);
        saw_ignt = (if_gnt === 1'b1);

        if (rst) begin
            m_busy = 1'b0; m_acc = 1'b0; m_streak = 0;
        end else if (!m_busy) begin
            if (e_ig || e_dg) begin
                m_busy  = 1'b1;
                m_acc   = 1'b0;
                m_own_d = pick_d;
                m_we    = pick_d ? d_we    : 1'b0;
                m_addr  = pick_d ? d_addr  : if_addr;
                m_wdata = pick_d ? d_wdata : '0;
                if (!pick_d)     m_streak = 0;
                else if (if_req) m_streak = (m_streak + 1 > SMAX) ? SMAX : m_streak + 1;
            end
        end else if (!m_acc) begin
            if (mem_gnt) m_acc = 1'b1;
        end else if (mem_rvalid) begin
            m_busy = 1'b0;
        end
    end

    task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
        vecs++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check_str(input string name, input string got, input string want);
        vecs++;
        if (got != want) begin
            errs++;
            $display("FAIL %s: got %s want %s", name, got, want);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while ((dq.size() > 0 || iq.size() > 0 || m_busy) && k < budget) begin
            @(posedge clk);
            k++;
        end
        vecs++;
        if (k >= budget) begin
            errs++;
            $display("FAIL %s_timeout: got %0d cycles want < %0d", name, k, budget);
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_outputs", {28'd0, mem_req, if_gnt, d_gnt, d_rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // single fetch, 3-cycle turnaround
        gnt_delay = 0; rsp_delay = 2; rsp_data = 32'h0050_0093; glog = "";
        iq.push_back(32'h100);
        wait_done("fetch", 50);
        check_str("fetch_order", glog, "I");
        check("fetch_latency", 32'(irv_cyc - ignt_cyc), 32'd3);
        check("fetch_rdata", irv_data, 32'h0050_0093);
        check("fetch_addr", maddr_seen, 32'h100);

        // simultaneous requests: data first, fetch right after
        rsp_delay = 1; rsp_data = 32'hCAFE_0001; glog = "";
        dq.push_back('{1'b0, 32'h2000, 32'h0});
        iq.push_back(32'h104);
        wait_done("simul", 50);
        check_str("simul_order", glog, "DI");
        check("simul_fetch_after", 32'(ignt_cyc - drv_cyc), 32'd1);

        // starvation cap
        glog = "";
        for (int i = 0; i < 5; i++) dq.push_back('{1'b0, 32'h2100 + 32'(4 * i), 32'h0});
        iq.push_back(32'h108);
        wait_done("starve", 200);
        check_str("starve_order", glog, "DDDDID");

        // store with delayed memory accept
        gnt_delay = 5; mreq_cycles = 0; wdata_seen = 1'b0; rv_count = 0;
        dq.push_back('{1'b1, 32'h2004, 32'hDEAD_BEEF});
        wait_done("store", 50);
        check("store_mreq_cycles", 32'(mreq_cycles), 32'd6);
        check("store_wdata_seen", {31'd0, wdata_seen}, 32'd1);
        check("store_ack", 32'(rv_count), 32'd1);

        // reset while waiting for response; stray response follows
        gnt_delay = 0; rsp_delay = 3; rv_count = 0;
        dq.push_back('{1'b0, 32'h3000, 32'h0});
        begin
            int k = 0;
            while (!(m_busy && m_acc) && k < 20) begin
                @(posedge clk);
                k++;
            end
            vecs++;
            if (k >= 20) begin
                errs++;
                $display("FAIL abort_reach_rsp: got %0d cycles want < 20", k);
            end
        end
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("abort_no_rvalid", 32'(rv_count), 32'd0);
        check("abort_outputs", {27'd0, mem_req, mem_we, if_gnt, d_gnt, if_rvalid}, 32'd0);
        check("abort_addr", mem_addr, 32'd0);

        // arbiter still usable after abort
        rsp_delay = 1; rsp_data = 32'h0BAD_F00D; glog = "";
        iq.push_back(32'h200);
        wait_done("post_abort", 50);
        check_str("post_abort_order", glog, "I");
        check("post_abort_rdata", irv_data, 32'h0BAD_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mem_arbiter

`default_nettype wire
